// File: rtl/sr_pulse_driver.sv
// Request conditioner for a NAND SR latch: synchronises and debounces set/clear requests and
// turns each debounced rising edge into one fixed-width, never-overlapping s or r pulse.
module sr_pulse_driver #(
  parameter int unsigned DB_CYCLES      = 16,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter bit          OUT_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES + 1);
  localparam int unsigned TmMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TmW   = $clog2(TmMax + 1);

  localparam logic [DbW-1:0] DbLast    = DbW'(DB_CYCLES - 1);
  localparam logic [TmW-1:0] PulseLast = TmW'(PULSE_CYCLES - 1);
  localparam logic [TmW-1:0] GapLast   = TmW'(GAP_CYCLES - 1);

  localparam logic OutOff = OUT_ACTIVE_LOW;
  localparam logic OutOn  = !OUT_ACTIVE_LOW;

  typedef enum logic [1:0] {StIdle, StSet, StClr, StGap} state_e;

  // Index 0 carries the set request, index 1 the clear request.
  logic [1:0]          req;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d, deb_prev_q;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          evt;
  logic                set_evt, clr_evt;

  logic                pend_set_q, pend_set_d;
  logic                pend_clr_q, pend_clr_d;
  state_e              state_q, state_d;
  logic [TmW-1:0]      tm_q, tm_d;
  logic                s_q, r_q, busy_q;

  assign req = {clr_req, set_req};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= req;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // The counter only survives an unbroken run of mismatches; any match restarts it.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign evt      = deb_q & ~deb_prev_q;
  assign set_evt  = evt[0];
  assign clr_evt  = evt[1];
  assign conflict = set_evt & clr_evt;

  always_comb begin
    state_d    = state_q;
    tm_d       = tm_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;

    case (state_q)
      StIdle: begin
        if (pend_set_q) begin
          state_d    = StSet;
          pend_set_d = 1'b0;
          tm_d       = '0;
        end else if (pend_clr_q) begin
          state_d    = StClr;
          pend_clr_d = 1'b0;
          tm_d       = '0;
        end
      end
      StSet, StClr: begin
        if (tm_q == PulseLast) begin
          state_d = StGap;
          tm_d    = '0;
        end else begin
          tm_d = tm_q + TmW'(1);
        end
      end
      StGap: begin
        if (tm_q == GapLast) begin
          state_d = StIdle;
          tm_d    = '0;
        end else begin
          tm_d = tm_q + TmW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tm_d    = '0;
      end
    endcase

    // Newer events override whatever is queued; a simultaneous pair cancels both.
    if (set_evt && clr_evt) begin
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
    end else if (set_evt) begin
      pend_set_d = 1'b1;
      pend_clr_d = 1'b0;
    end else if (clr_evt) begin
      pend_set_d = 1'b0;
      pend_clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tm_q       <= '0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      s_q        <= OutOff;
      r_q        <= OutOff;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tm_q       <= tm_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      // Outputs registered from the next state so they switch together with state_q.
      s_q        <= (state_d == StSet) ? OutOn : OutOff;
      r_q        <= (state_d == StClr) ? OutOn : OutOff;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with DB_CYCLES=4, PULSE_CYCLES=3, GAP_CYCLES=2,
// active-low outputs; expected waveforms are hand-derived edge by edge.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_pulse_driver #(
    .DB_CYCLES     (4),
    .PULSE_CYCLES  (3),
    .GAP_CYCLES    (2),
    .OUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .conflict(conflict)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic es, input logic er, input logic eb,
                         input logic ec);
    chk({tag, " s"}, s, es);
    chk({tag, " r"}, r, er);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " conflict"}, conflict, ec);
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // s and r must never be active (low) together.
  always @(negedge clk) begin
    chk("overlap", (s === 1'b0) && (r === 1'b0), 1'b0);
  end

  initial begin
    // 1: asynchronous reset with arbitrary request levels
    rst_n   = 1'b1;
    set_req = 1'($urandom_range(0, 1));
    clr_req = 1'($urandom_range(0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t1 reset", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk_out("t1 held", 1'b1, 1'b1, 1'b0, 1'b0);
    set_req = 1'b0;
    clr_req = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk_out("t1 idle", 1'b1, 1'b1, 1'b0, 1'b0);

    // 2: clean set request, s low on edges 8..10, gap on 11..12
    set_req = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      step();
      chk_out($sformatf("t2 e%0d", e), !(e >= 8 && e <= 10), 1'b1, (e >= 8 && e <= 12), 1'b0);
    end
    set_req = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk_out($sformatf("t2 fall e%0d", e), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 3: bounce shorter than the debounce window never produces a pulse
    for (int i = 0; i < 20; i++) begin
      set_req = ((i / 2) % 2) == 0;
      step();
      chk_out($sformatf("t3 bounce %0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    set_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("t3 settle %0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 4: clear queued behind a set pulse, then set-then-clear during the r pulse;
    // only the later clear is served afterwards.
    set_req = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      chk_out($sformatf("t4 e%0d", e),
              !(e >= 8 && e <= 10),
              !((e >= 14 && e <= 16) || (e >= 20 && e <= 22)),
              (e >= 8 && e <= 12) || (e >= 14 && e <= 18) || (e >= 20 && e <= 24),
              1'b0);
      case (e)
        2:       clr_req = 1'b1;
        4:       set_req = 1'b0;
        6:       clr_req = 1'b0;
        8:       set_req = 1'b1;
        10:      clr_req = 1'b1;
        default: ;
      endcase
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk_out($sformatf("t4 fall e%0d", e), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 5: simultaneous requests flag a conflict for one cycle and issue nothing
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk_out($sformatf("t5 e%0d", e), 1'b1, 1'b1, 1'b0, (e == 6));
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (12) step();

    // 6: reset in the second cycle of an r pulse
    clr_req = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      chk_out($sformatf("t6 e%0d", e), 1'b1, !(e >= 8), (e >= 8), 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6 async", 1'b1, 1'b1, 1'b0, 1'b0);
    clr_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk_out($sformatf("t6 after e%0d", e), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
